opener: RTL and testbench
=========================

# opener

Garage-door opener controller: a four-state Moore machine that drives the door motor up (`u`) or down (`d`) from a wall button, the two end-of-travel limit sensors and a safety (obstruction) beam. It sits between the debounced operator and sensor inputs and the motor driver. It exposes its state encoding for status display and test.

## Interface
Parameters: none. State encodings are fixed as localparams: Closed = 2'd0, Opening = 2'd1, Open = 2'd2, Closing = 2'd3.

Ports:
- `clk`  input  1  system clock; the only clock. All state changes occur on its rising edge.
- `r`  input  1  reset. Asynchronous and active-low (0 = reset).
- `b`  input  1  operator button, synchronous to `clk`. 1 = pressed.
- `c`  input  1  closed limit sensor. 1 = door fully closed.
- `o`  input  1  open limit sensor. 1 = door fully open.
- `s`  input  1  safety beam. 1 = obstruction detected.
- `d`  output  1  motor down command.
- `u`  output  1  motor up command.
- `State`  output  2  current state encoding.

## Operation
- Outputs are Moore-decoded from `State` only:
  - Opening: `u`=1, `d`=0.
  - Closing: `u`=0, `d`=1.
  - Closed and Open: `u`=0, `d`=0.
  - `u` and `d` are never 1 together.
- Reset state depends on the sensors while `r`=0:
  - `c`=1 → Closed. `c` has priority if `c` and `o` are both 1.
  - else `o`=1 → Open.
  - else (door mid-travel) → Opening.
- "press" means button event (see Configuration).
- Closed: press → Opening; otherwise hold.
- Opening, in priority order:
  - `o`=1 → Open.
  - else press → Closing (reverse).
  - else hold.
- Open: press → Closing; otherwise hold.
- Closing, in priority order:
  - `c`=1 → Closed.
  - else `s`=1 → Opening (safety reversal; overrides press).
  - else press → Opening.
  - else hold.
- The state register is 2 bits. All four codes are legal; no illegal-state recovery is needed.

## Timing
- While `r`=0, `State`, `u` and `d` continuously track the sensor-selected reset state, with no clock needed. Sensor changes during reset propagate combinationally.
- After `r` rises, `State` keeps the last reset value until the first rising `clk` edge, even if the sensors change at the same instant as `r`.
- Next-state latency is one clock. `u`, `d` and `State` change only on rising `clk` edges, or asynchronously during reset. There is no extra output pipeline.
- A limit sensor and a button event in the same cycle: the sensor wins.
- Reset asserted mid-travel aborts motion immediately. The block then follows the reset-state rule above.

## Configuration
- `OPENER_BTN_EDGE_EN` defined:
  - A press is the rising edge of `b`: `b`=1 in this cycle and the registered `b_q`=0.
  - `b_q` resets to 1, so a button held through reset does not produce a press.
  - Holding `b` gives exactly one press.
- Not defined:
  - A press is `b`=1 sampled at each rising edge (level).
  - Holding `b` in Open gives Open → Closing → Opening → Closing … on successive edges.

## Test plan
- `r`=0 with `c`=0, `o`=0, `b`=0, `s`=0; release `r` → immediately after release `State`=Opening(1), `u`=1, `d`=0. It remains Opening while `o`=0.
- `r`=0 with `o`=1; release `r` and drop `o` at the same instant → `State`=Open(2), `u`=0, `d`=0. It remains Open with `b`=0.
- `r`=0 with `c`=1; release `r` → `State`=Closed(0), `u`=0, `d`=0. Also `r`=0 with `c`=`o`=1 → Closed.
- From Closed:
  - press → Opening(`u`=1).
  - assert `o` → Open.
  - press → Closing(`d`=1).
  - assert `c` → Closed, one clock per transition.
- From Closing, assert `s`=1 → Opening next edge with `u`=1. With `s`=1 and `c`=1 together → Closed.
- With `OPENER_BTN_EDGE_EN`, hold `b`=1 for 5 cycles in Open → a single Closing transition. Without the macro → the state toggles Closing/Opening each cycle.

Source files
------------

// File: rtl/opener.sv
// opener: garage-door opener Moore FSM driving motor up/down from button, limit sensors and safety beam.
// Define OPENER_BTN_EDGE_EN to make a press the rising edge of b instead of its level.
module opener (
    input  logic       clk,
    input  logic       r,
    input  logic       b,
    input  logic       c,
    input  logic       o,
    input  logic       s,
    output logic       d,
    output logic       u,
    output logic [1:0] State
);
    localparam logic [1:0] CLOSED = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3;
    logic [1:0] state_q, state_d, rst_state;
    logic       press;
    assign rst_state = c ? CLOSED : o ? OPEN : OPENING;
`ifdef OPENER_BTN_EDGE_EN
    logic b_q;
    // Resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge r)
        if (!r) b_q <= 1'b1;
        else    b_q <= b;
    assign press = b & ~b_q;
`else
    assign press = b;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLOSED:  state_d = press ? OPENING : CLOSED;
            OPENING: state_d = o ? OPEN : press ? CLOSING : OPENING;
            OPEN:    state_d = press ? CLOSING : OPEN;
            default: state_d = c ? CLOSED : (s | press) ? OPENING : CLOSING;
        endcase
    end
    always_ff @(posedge clk or negedge r)
        if (!r) state_q <= rst_state;
        else    state_q <= state_d;
    // While in reset the visible state follows the sensors without waiting for a clock.
    assign State = r ? state_q : rst_state;
    assign u = (State == OPENING);
    assign d = (State == CLOSING);
endmodule

// File: tb/tb_opener.sv
// tb_opener: vector-table and scoreboard bench for the opener controller.
module tb_opener;
    logic clk = 1'b0, r = 1'b0, b = 1'b0, c = 1'b0, o = 1'b0, s = 1'b0;
    logic d, u;
    logic [1:0] State;
    int n_cmp = 0, n_bad = 0;
    typedef struct packed {
        logic r, b, c, o, s;
        logic [1:0] st;
    } vec_t;
    vec_t vecs[$];
    logic [1:0] sb[$];

    opener dut (.clk(clk), .r(r), .b(b), .c(c), .o(o), .s(s), .d(d), .u(u), .State(State));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] exp);
        logic [3:0] act, req;
        act = {State, u, d};
        req = {exp, exp == 2'd1, exp == 2'd3};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got State=%0d u=%b d=%b, want State=%0d u=%b d=%b",
                     name, act[3:2], act[1], act[0], req[3:2], req[1], req[0]);
        end
    endtask

    task automatic add(input logic vr, vb, vc, vo, vs, input logic [1:0] st);
        vec_t v;
        v = {vr, vb, vc, vo, vs, st};
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] exp;
        //   r     b     c     o     s     expected state
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            {r, b, c, o, s} = {vecs[i].r, vecs[i].b, vecs[i].c, vecs[i].o, vecs[i].s};
            sb.push_back(vecs[i].st);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), sb.pop_front());
        end
        // Sensor changes in reset propagate without a clock.
        @(negedge clk);
        r = 1'b0; b = 1'b0; c = 1'b0; o = 1'b0; s = 1'b0;
        #1 check("async_mid", 2'd1);
        c = 1'b1;
        #1 check("async_closed", 2'd0);
        c = 1'b0; o = 1'b1;
        #1 check("async_open", 2'd2);
        @(posedge clk);
        #1 check("rst_clocked_open", 2'd2);
        // Release reset and drop o together: last reset value holds.
        @(negedge clk);
        r = 1'b1; o = 1'b0;
        #1 check("release_same_instant", 2'd2);
        @(posedge clk);
        #1 check("open_hold", 2'd2);
        // Hold the button for five cycles in Open.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b = 1'b1;
`ifdef OPENER_BTN_EDGE_EN
            exp = 2'd3;
`else
            exp = (i % 2 == 0) ? 2'd3 : 2'd1;
`endif
            sb.push_back(exp);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", i), sb.pop_front());
        end
        @(negedge clk);
        b = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
